// File: rtl/ttl_pkg.sv
// Shared types and terminal-count helper for the 74x163-style counter chain.
package ttl_pkg;

    localparam logic [3:0] NIBBLE_MAX = 4'hF;

    typedef logic [3:0] nibble_t;

    // Terminal value for a chain of `stages` nibbles; modulo 0 means natural 2^W wrap.
    function automatic logic [31:0] tc_value(input int stages, input int modulo);
        logic [63:0] full;
        full = (64'd1 << (4 * stages)) - 64'd1;
        if (modulo == 0)
            return full[31:0];
        return 32'(modulo - 1);
    endfunction

endpackage

// File: rtl/ttl_74x163_stage.sv
// One 4-bit synchronous counter stage, behaviourally equivalent to a 74x163 package.
module ttl_74x163_stage
    import ttl_pkg::*;
(
    input  logic    clk,
    input  logic    clr,
    input  logic    load,
    input  nibble_t d,
    input  logic    enp,
    input  logic    ent,
    output nibble_t q,
    output logic    rco
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (load)
            q <= d;
        else if (enp && ent)
            q <= q + 4'd1;
    end

    assign rco = ent & (q == NIBBLE_MAX);

endmodule

// File: rtl/ttl_counter_chain.sv
// Cascaded 74x163-style up-counter with optional modulo wrap and registered wrap pulse.
module ttl_counter_chain
    import ttl_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int MODULO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*STAGES-1:0]   d,
    input  logic                  enp,
    input  logic                  ent,
    output logic [4*STAGES-1:0]   q,
    output logic [STAGES-1:0]     stage_rco,
    output logic                  rco,
    output logic                  wrap
);

    localparam int W = 4 * STAGES;
    localparam logic [W-1:0] TC = W'(tc_value(STAGES, MODULO));

    logic            at_tc;
    logic            count_tc;
    logic            clr;
    logic [STAGES:0] t;

    assign at_tc    = (q == TC);
    // A stage's clear beats its load, so the decoded clear must yield to load here.
    assign count_tc = enp & ent & at_tc & ~load;
    assign clr      = rst | count_tc;

    assign t[0] = ent;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        ttl_74x163_stage u_stage (
            .clk  (clk),
            .clr  (clr),
            .load (load),
            .d    (d[4*i +: 4]),
            .enp  (enp),
            .ent  (t[i]),
            .q    (q[4*i +: 4]),
            .rco  (t[i+1])
        );
    end

    assign stage_rco = t[STAGES:1];
    assign rco       = ent & at_tc;

    always_ff @(posedge clk) begin
        if (rst)
            wrap <= 1'b0;
        else
            wrap <= count_tc;
    end

endmodule
